// File: rtl/fracn_clk_pkg.sv
// Shared types and defaults for the fractional-N clock-enable generator.
// Channel state encoding, default sizing and settle-counter width helper.
package fracn_clk_pkg;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_SETTLE = 2'd1,
    CH_RUN    = 2'd2
  } ch_state_e;

  localparam int DEF_ACC_W       = 32;
  localparam int DEF_LOCK_CYCLES = 1024;

  function automatic int cnt_w(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/fracn_acc_ch.sv
// One phase-accumulator channel: state machine, settle counter, outputs.
// FRACN_PHASE_EN adds a per-channel start-phase register.
module fracn_acc_ch
  import fracn_clk_pkg::*;
#(
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_stop,
  input  logic             i_sync,
  input  logic [ACC_W-1:0] i_inc,
  input  logic [ACC_W-1:0] i_phase,
  output logic             o_ce,
  output logic             o_tick,
  output logic             o_locked
);

  localparam int CNT_W = cnt_w(LOCK_CYCLES);

  ch_state_e        r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ce;
  logic             r_tick;
  logic             r_locked;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_start;
  logic [ACC_W-1:0] w_load_val;

`ifdef FRACN_PHASE_EN
  logic [ACC_W-1:0] r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (i_load) begin
      r_phase <= i_phase;
    end
  end

  assign w_start    = r_phase;
  assign w_load_val = i_phase;
`else
  logic w_unused_phase;

  assign w_unused_phase = ^i_phase;
  assign w_start        = '0;
  assign w_load_val     = '0;
`endif

  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CH_IDLE;
      r_acc    <= '0;
      r_inc    <= '0;
      r_cnt    <= '0;
      r_ce     <= 1'b0;
      r_tick   <= 1'b0;
      r_locked <= 1'b0;
    end else if (i_load) begin
      r_state  <= CH_SETTLE;
      r_inc    <= i_inc;
      r_acc    <= w_load_val;
      r_cnt    <= '0;
      r_ce     <= 1'b0;
      r_tick   <= 1'b0;
      r_locked <= 1'b0;
    end else if (i_stop) begin
      r_state  <= CH_IDLE;
      r_acc    <= '0;
      r_ce     <= 1'b0;
      r_tick   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      unique case (r_state)
        CH_SETTLE: begin
          r_acc  <= w_sum[ACC_W-1:0];
          r_ce   <= 1'b0;
          r_tick <= 1'b0;
          if (r_cnt == CNT_W'(LOCK_CYCLES)) begin
            r_state  <= CH_RUN;
            r_locked <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CH_RUN: begin
          // restart keeps RUN; tick mirrors the reloaded MSB
          if (i_sync) begin
            r_acc  <= w_start;
            r_ce   <= 1'b0;
            r_tick <= w_start[ACC_W-1];
          end else begin
            r_acc  <= w_sum[ACC_W-1:0];
            r_ce   <= w_sum[ACC_W];
            r_tick <= w_sum[ACC_W-1];
          end
        end
        default: begin
          r_ce     <= 1'b0;
          r_tick   <= 1'b0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_ce     = r_ce;
  assign o_tick   = r_tick;
  assign o_locked = r_locked;

endmodule

// File: rtl/fracn_clk_gen.sv
// Multi-channel fractional-N clock-enable generator (config decode, sync).
// Optional macro FRACN_PHASE_EN: cfg_phase sets each channel's start value.
module fracn_clk_gen
  import fracn_clk_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              sync,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] locked
);

  logic r_ready;
  logic r_err;
  logic w_xfer;
  logic w_bad_ch;
  logic w_inc_zero;

  assign w_xfer     = cfg_valid & r_ready;
  assign w_bad_ch   = ({29'd0, cfg_ch} >= 32'(NUM_CH));
  assign w_inc_zero = (cfg_inc == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_xfer & w_bad_ch;
    end
  end

  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_sel;

    // the configured channel ignores a simultaneous sync
    assign w_sel = w_xfer & ~w_bad_ch & (cfg_ch == 3'(g));

    fracn_acc_ch #(
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_sel & ~w_inc_zero),
      .i_stop   (w_sel & w_inc_zero),
      .i_sync   (sync & ~w_sel),
      .i_inc    (cfg_inc),
      .i_phase  (cfg_phase),
      .o_ce     (ce[g]),
      .o_tick   (tick[g]),
      .o_locked (locked[g])
    );
  end

endmodule

// File: tb/tb_fracn_clk_gen.sv
// Directed bench for fracn_clk_gen with ACC_W=8, LOCK_CYCLES=4, NUM_CH=2.
// Expected values are hand-derived accumulator traces.
module tb_fracn_clk_gen;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_inc;
  logic [7:0] cfg_phase;
  logic       sync;
  logic       cfg_err;
  logic [1:0] ce;
  logic [1:0] tick;
  logic [1:0] locked;

  int n_cmp;
  int n_bad;

  fracn_clk_gen #(
    .NUM_CH      (2),
    .ACC_W       (8),
    .LOCK_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .sync      (sync),
    .cfg_err   (cfg_err),
    .ce        (ce),
    .tick      (tick),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] cap_ce;
    logic [7:0] cap_tk;
    logic [9:0] cap_ce10;
    logic [9:0] cap_lk10;
    logic [4:0] cap_ce5;
    logic [4:0] cap_tk5;
    logic       prev;
    int         cnt;
    int         adj;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch = 3'd0;
    cfg_inc = 8'd0;
    cfg_phase = 8'd0;
    sync = 1'b0;

    cyc();
    cyc();
    chk("rst_outs", {27'd0, cfg_ready, cfg_err, ce, tick, locked}, 32'd0);
    rst_n = 1'b1;
    chk("ready_before_edge", {31'd0, cfg_ready}, 32'd0);
    cyc();
    chk("ready_after_edge", {31'd0, cfg_ready}, 32'd1);

    // ch0 inc=64
    cfg_valid = 1'b1;
    cfg_ch = 3'd0;
    cfg_inc = 8'd64;
    cyc();
    cfg_valid = 1'b0;
    chk("ch0_settle_locked", {30'd0, locked}, 32'd0);
    for (int i = 1; i <= 3; i++) cyc();
    cyc();
    chk("ch0_locked_n4", {31'd0, locked[0]}, 32'd0);
    cyc();
    chk("ch0_locked_n5", {31'd0, locked[0]}, 32'd1);
    chk("ch0_ce_at_lock", {31'd0, ce[0]}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      cap_ce[i] = ce[0];
      cap_tk[i] = tick[0];
    end
    chk("ch0_ce_pattern", {24'd0, cap_ce}, {24'd0, 8'b0100_0100});
    chk("ch0_tick_pattern", {24'd0, cap_tk}, {24'd0, 8'b0011_0011});
    chk("ch1_idle", {30'd0, ce[1], locked[1]}, 32'd0);

    // ch1 inc=96
    cfg_valid = 1'b1;
    cfg_ch = 3'd1;
    cfg_inc = 8'd96;
    cyc();
    cfg_valid = 1'b0;
    for (int i = 1; i <= 4; i++) cyc();
    chk("ch1_locked_m4", {31'd0, locked[1]}, 32'd0);
    cyc();
    chk("ch1_locked_m5", {31'd0, locked[1]}, 32'd1);
    cnt = 0;
    adj = 0;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (ce[1]) cnt++;
      if (ce[1] && prev) adj++;
      prev = ce[1];
    end
    chk("ch1_ce_count", cnt, 32'd6);
    chk("ch1_ce_adjacent", adj, 32'd0);

    // retune ch0 to 128 while running
    cfg_valid = 1'b1;
    cfg_ch = 3'd0;
    cfg_inc = 8'd128;
    cyc();
    cfg_valid = 1'b0;
    chk("retune_locked_drop", {30'd0, locked}, 32'd2);
    chk("retune_ce0", {31'd0, ce[0]}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      cap_ce10[i] = ce[0];
      cap_lk10[i] = locked[0];
    end
    chk("retune_ce_pattern", {22'd0, cap_ce10}, {22'd0, 10'b10_1010_0000});
    chk("retune_lock_pattern", {22'd0, cap_lk10}, {22'd0, 10'b11_1111_0000});

    // bad channel index
    cfg_valid = 1'b1;
    cfg_ch = 3'd5;
    cfg_inc = 8'd32;
    cyc();
    cfg_valid = 1'b0;
    chk("bad_ch_err", {31'd0, cfg_err}, 32'd1);
    chk("bad_ch_locked", {30'd0, locked}, 32'd3);
    chk("bad_ch_ce0_idle", {31'd0, ce[0]}, 32'd0);
    cyc();
    chk("bad_ch_err_clear", {31'd0, cfg_err}, 32'd0);
    chk("bad_ch_ce0_next", {31'd0, ce[0]}, 32'd1);

    // ch0 back to 64, then sync alongside a ch1 config
    cfg_valid = 1'b1;
    cfg_ch = 3'd0;
    cfg_inc = 8'd64;
`ifdef FRACN_PHASE_EN
    cfg_phase = 8'd128;
`endif
    cyc();
    cfg_valid = 1'b0;
    cfg_phase = 8'd0;
    for (int i = 1; i <= 8; i++) cyc();
    chk("pre_sync_locked", {30'd0, locked}, 32'd3);
    sync = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch = 3'd1;
    cfg_inc = 8'd96;
    cyc();
    sync = 1'b0;
    cfg_valid = 1'b0;
    chk("sync_locked", {30'd0, locked}, 32'd1);
    chk("sync_ce0", {31'd0, ce[0]}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      cap_ce5[i] = ce[0];
      cap_tk5[i] = tick[0];
    end
`ifdef FRACN_PHASE_EN
    chk("sync_ce_pattern", {27'd0, cap_ce5}, {27'd0, 5'b00010});
    chk("sync_tick_pattern", {27'd0, cap_tk5}, {27'd0, 5'b11001});
`else
    chk("sync_ce_pattern", {27'd0, cap_ce5}, {27'd0, 5'b01000});
    chk("sync_tick_pattern", {27'd0, cap_tk5}, {27'd0, 5'b00110});
`endif
    chk("sync_ch1_relock", {30'd0, locked}, 32'd3);

    // inc=0 stops ch1
    cfg_valid = 1'b1;
    cfg_ch = 3'd1;
    cfg_inc = 8'd0;
    cyc();
    cfg_valid = 1'b0;
    chk("stop_ch1", {30'd0, locked}, 32'd1);
    cyc();
    chk("stop_ch1_quiet", {30'd0, ce[1], tick[1]}, 32'd0);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {27'd0, cfg_ready, cfg_err, ce, tick, locked}, 32'd0);
    cyc();
    chk("rst_hold_ready", {31'd0, cfg_ready}, 32'd0);
    rst_n = 1'b1;
    chk("rel_ready_low", {31'd0, cfg_ready}, 32'd0);
    cyc();
    chk("rel_ready_high", {31'd0, cfg_ready}, 32'd1);
    chk("rel_locked", {30'd0, locked}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
